// File: rtl/xif_copro_exec.sv
// xif_copro_exec: XIF coprocessor execute/writeback stage. It keeps an in-order issue queue, waits for commit or kill, computes the result and returns it.
// Optional feature: define XIF_COPRO_EXEC_PERF_EN to build the saturating perf counters. Without it, both counters read as 0.

package xif_copro_pkg;
   typedef enum logic [1:0] {NONE = 2'd0, BITREV = 2'd1, ROTRIGHT = 2'd2, ROTLEFT = 2'd3} copro_op_e;
endpackage

module xif_copro_exec
   import xif_copro_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ID_WIDTH = 4,
   parameter int unsigned XLEN     = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [ID_WIDTH-1:0] issue_id_i,
   input  copro_op_e           issue_op_i,
   input  logic [XLEN-1:0]     issue_rs1_i,
   input  logic [XLEN-1:0]     issue_rs2_i,
   input  logic [4:0]          issue_rd_i,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic [4:0]          result_rd_o,
   output logic                result_we_o,
   output logic [XLEN-1:0]     result_data_o,
   output logic                busy_o,
   output logic [31:0]         perf_retired_o,
   output logic [31:0]         perf_killed_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ID_WIDTH-1:0]   id_q  [DEPTH];
   copro_op_e             op_q  [DEPTH];
   logic [XLEN-1:0]       rs1_q [DEPTH];
   logic [4:0]            amt_q [DEPTH];
   logic [4:0]            dst_q [DEPTH];
   logic [DEPTH-1:0]      vld_q, vld_d, com_q, com_d, kil_q, kil_d;
   logic [AW-1:0]         h, w;
   logic                  full, empty, issue_fire, same_cm, can_load, pop_kill, pop_exec, pop;
   logic [2*XLEN-1:0]     dbl, shr, shl;
   logic [XLEN-1:0]       rev, exec_data;
   logic                  res_valid_q, res_we_q;
   logic [ID_WIDTH-1:0]   res_id_q;
   logic [4:0]            res_rd_q;
   logic [XLEN-1:0]       res_data_q;
   logic                  unused_rs2;

   assign unused_rs2    = ^issue_rs2_i[XLEN-1:5];
   assign h             = rptr_q[AW-1:0];
   assign w             = wptr_q[AW-1:0];
   assign empty         = wptr_q == rptr_q;
   assign full          = (wptr_q[AW] != rptr_q[AW]) && (w == h);
   assign issue_ready_o = !full;
   assign issue_fire    = issue_valid_i && !full;
   assign same_cm       = commit_valid_i && (commit_id_i == issue_id_i);
   assign can_load      = !res_valid_q || result_ready_i;
   assign pop_kill      = !empty && kil_q[h];
   assign pop_exec      = !empty && !kil_q[h] && com_q[h] && can_load;
   assign pop           = pop_kill || pop_exec;
   assign wptr_d        = wptr_q + {{AW{1'b0}}, issue_fire};
   assign rptr_d        = rptr_q + {{AW{1'b0}}, pop};
   assign busy_o        = !empty || res_valid_q;

   // Per-entry flags: commit/kill marks matching entries, including one enqueued this cycle.
   always_comb begin
      vld_d = vld_q;
      com_d = com_q;
      kil_d = kil_q;
      for (int i = 0; i < DEPTH; i++)
         if (commit_valid_i && vld_q[i] && id_q[i] == commit_id_i) begin
            kil_d[i] = kil_q[i] | commit_kill_i;
            com_d[i] = com_q[i] | !commit_kill_i;
         end
      if (pop) begin
         vld_d[h] = 1'b0;
         com_d[h] = 1'b0;
         kil_d[h] = 1'b0;
      end
      if (issue_fire) begin
         vld_d[w] = 1'b1;
         com_d[w] = same_cm && !commit_kill_i;
         kil_d[w] = same_cm && commit_kill_i;
      end
   end

   // Queue pointers and entry flags.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         vld_q  <= '0;
         com_q  <= '0;
         kil_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         vld_q  <= vld_d;
         com_q  <= com_d;
         kil_q  <= kil_d;
      end

   // Entry payload, qualified by the flags so it needs no reset.
   always_ff @(posedge clk_i)
      if (issue_fire) begin
         id_q[w]  <= issue_id_i;
         op_q[w]  <= issue_op_i;
         rs1_q[w] <= issue_rs1_i;
         amt_q[w] <= issue_rs2_i[4:0];
         dst_q[w] <= issue_rd_i;
      end

   // Head execution: rotates take a window of the doubled operand, so n=0 returns rs1.
   always_comb begin
      dbl = {rs1_q[h], rs1_q[h]};
      shr = dbl >> amt_q[h];
      shl = dbl << amt_q[h];
      rev = '0;
      for (int i = 0; i < XLEN; i++) rev[i] = rs1_q[h][XLEN-1-i];
      exec_data = op_q[h] == BITREV   ? rev :
                  op_q[h] == ROTRIGHT ? shr[XLEN-1:0] :
                  op_q[h] == ROTLEFT  ? shl[2*XLEN-1:XLEN] : '0;
   end

   // Result register: reload on exec pop, otherwise clear once the CPU accepts.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_rd_q    <= '0;
         res_we_q    <= 1'b0;
         res_data_q  <= '0;
      end else if (pop_exec) begin
         res_valid_q <= 1'b1;
         res_id_q    <= id_q[h];
         res_rd_q    <= dst_q[h];
         res_we_q    <= op_q[h] != NONE;
         res_data_q  <= exec_data;
      end else if (result_ready_i) begin
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_rd_q    <= '0;
         res_we_q    <= 1'b0;
         res_data_q  <= '0;
      end

   assign result_valid_o = res_valid_q;
   assign result_id_o    = res_id_q;
   assign result_rd_o    = res_rd_q;
   assign result_we_o    = res_we_q;
   assign result_data_o  = res_data_q;

`ifdef XIF_COPRO_EXEC_PERF_EN
   logic [31:0] ret_q, ret_d, kcnt_q, kcnt_d;

   assign ret_d  = (res_valid_q && result_ready_i && !(&ret_q)) ? ret_q + 32'd1 : ret_q;
   assign kcnt_d = (pop_kill && !(&kcnt_q)) ? kcnt_q + 32'd1 : kcnt_q;

   // Saturating retire/kill counters.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         ret_q  <= '0;
         kcnt_q <= '0;
      end else begin
         ret_q  <= ret_d;
         kcnt_q <= kcnt_d;
      end

   assign perf_retired_o = ret_q;
   assign perf_killed_o  = kcnt_q;
`else
   assign perf_retired_o = '0;
   assign perf_killed_o  = '0;
`endif
endmodule

// File: tb/tb_xif_copro_exec.sv
// tb_xif_copro_exec: directed and randomized checks of xif_copro_exec against an in-bench reference model.
module tb_xif_copro_exec;
   import xif_copro_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        issue_valid_i = 1'b0;
   logic        issue_ready_o;
   logic [3:0]  issue_id_i = '0;
   copro_op_e   issue_op_i = NONE;
   logic [31:0] issue_rs1_i = '0;
   logic [31:0] issue_rs2_i = '0;
   logic [4:0]  issue_rd_i = '0;
   logic        commit_valid_i = 1'b0;
   logic [3:0]  commit_id_i = '0;
   logic        commit_kill_i = 1'b0;
   logic        result_valid_o;
   logic        result_ready_i = 1'b1;
   logic [3:0]  result_id_o;
   logic [4:0]  result_rd_o;
   logic        result_we_o;
   logic [31:0] result_data_o;
   logic        busy_o;
   logic [31:0] perf_retired_o;
   logic [31:0] perf_killed_o;

`ifdef XIF_COPRO_EXEC_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic [3:0]  id;
      copro_op_e   op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      bit          kill;
   } ent_t;

   int          checks = 0;
   int          errors = 0;
   int          exp_ret = 0;
   int          exp_kil = 0;
   logic [41:0] mon_q[$];
   ent_t        ents[$];
   int          pend[$];

   xif_copro_exec dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
      .issue_op_i(issue_op_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
      .result_rd_o(result_rd_o), .result_we_o(result_we_o), .result_data_o(result_data_o),
      .busy_o(busy_o), .perf_retired_o(perf_retired_o), .perf_killed_o(perf_killed_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] m_exec(input copro_op_e op, input logic [31:0] a, input logic [31:0] b);
      int n;
      logic [31:0] r;
      n = int'(b % 32);
      r = '0;
      for (int i = 0; i < 32; i++)
         case (op)
            BITREV:   r[i] = a[31-i];
            ROTRIGHT: r[i] = a[(i + n) % 32];
            ROTLEFT:  r[i] = a[(i - n + 32) % 32];
            default:  r[i] = 1'b0;
         endcase
      return r;
   endfunction

   function automatic logic [41:0] m_pack(input ent_t e);
      return {e.id, e.rd, e.op != NONE, m_exec(e.op, e.a, e.b)};
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic step;
      if (result_valid_o && result_ready_i)
         mon_q.push_back({result_id_o, result_rd_o, result_we_o, result_data_o});
      tick();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_issue(input logic [3:0] id, input copro_op_e op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input bit cm);
      issue_valid_i  = 1'b1;
      issue_id_i     = id;
      issue_op_i     = op;
      issue_rs1_i    = a;
      issue_rs2_i    = b;
      issue_rd_i     = rd;
      commit_valid_i = cm;
      commit_id_i    = id;
      commit_kill_i  = 1'b0;
      tick();
      issue_valid_i  = 1'b0;
      commit_valid_i = 1'b0;
   endtask

   task automatic drive_commit(input logic [3:0] id, input bit kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      step();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
   endtask

   task automatic run1(input string tag, input logic [3:0] id, input copro_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
      drive_issue(id, op, a, b, 5'(id + 3), 1'b1);
      chk({tag, "_early"}, result_valid_o, 0);
      tick();
      chk({tag, "_valid"}, result_valid_o, 1);
      chk({tag, "_data"}, result_data_o, exp);
      chk({tag, "_idwe"}, {result_id_o, result_rd_o, result_we_o}, {id, 5'(id + 3), 1'b1});
      tick();
      chk({tag, "_clear"}, result_valid_o, 0);
      exp_ret++;
   endtask

   initial begin
      logic [42:0] prev;
      bit          prev_stall;
      logic [3:0]  next_id;
      ent_t        e;
      int          k;
      int          nexp;

      tick();
      tick();
      chk("rst_ready", issue_ready_o, 1);
      chk("rst_outs", {result_valid_o, busy_o, result_id_o, result_rd_o, result_we_o, result_data_o}, 0);
      rst_ni = 1'b1;
      tick();
      chk("post_rst", {issue_ready_o, result_valid_o, busy_o}, 3'b100);
      chk("rst_perf", {perf_retired_o, perf_killed_o}, 0);

      run1("bitrev", 4'd1, BITREV, 32'h0000_0001, 32'h0, 32'h8000_0000);
      run1("rotr", 4'd2, ROTRIGHT, 32'h1234_5678, 32'd8, 32'h7812_3456);
      run1("rotl", 4'd3, ROTLEFT, 32'h8000_0001, 32'd1, 32'h0000_0003);
      run1("rotl32", 4'd4, ROTLEFT, 32'hCAFE_F00D, 32'h20, 32'hCAFE_F00D);

      for (int i = 1; i <= 4; i++) begin
         chk("fill_ready", issue_ready_o, 1);
         drive_issue(4'(i), BITREV, 32'h1 << i, 32'h0, 5'(i), 1'b0);
      end
      chk("full_ready", issue_ready_o, 0);
      drive_commit(4'd1, 1'b0);
      chk("pop_cycle_ready", issue_ready_o, 0);
      issue_valid_i = 1'b1;
      issue_id_i    = 4'd15;
      issue_op_i    = NONE;
      tick();
      issue_valid_i = 1'b0;
      chk("ready_after_pop", issue_ready_o, 1);
      chk("full_res", {result_valid_o, result_id_o, result_data_o}, {1'b1, 4'd1, 32'h4000_0000});
      exp_ret++;
      drive_commit(4'd2, 1'b1);
      drive_commit(4'd3, 1'b1);
      drive_commit(4'd4, 1'b1);
      exp_kil += 3;
      for (int i = 0; i < 4; i++) tick();
      chk("full_drained", {busy_o, result_valid_o}, 0);

      mon_q.delete();
      drive_issue(4'd2, ROTLEFT, 32'h0000_00F1, 32'd4, 5'd2, 1'b0);
      drive_issue(4'd3, ROTLEFT, 32'h0000_00F2, 32'd4, 5'd3, 1'b0);
      drive_issue(4'd4, ROTLEFT, 32'h0000_00F3, 32'd4, 5'd4, 1'b0);
      drive_commit(4'd2, 1'b0);
      drive_commit(4'd3, 1'b1);
      drive_commit(4'd4, 1'b0);
      for (int i = 0; i < 8; i++) step();
      exp_ret += 2;
      exp_kil++;
      chk("kill_count", mon_q.size(), 2);
      chk("kill_first", mon_q.size() > 0 ? mon_q[0] : 42'h0, {4'd2, 5'd2, 1'b1, 32'h0000_0F10});
      chk("kill_second", mon_q.size() > 1 ? mon_q[1] : 42'h0, {4'd4, 5'd4, 1'b1, 32'h0000_0F30});
      chk("kill_perf", {perf_retired_o, perf_killed_o}, PERF ? {32'(exp_ret), 32'(exp_kil)} : 64'h0);

      result_ready_i = 1'b0;
      drive_issue(4'd5, ROTRIGHT, 32'hA5A5_0F0F, 32'd4, 5'd9, 1'b1);
      drive_issue(4'd6, BITREV, 32'h0000_FFFF, 32'd0, 5'd10, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_hold", {result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o},
             {1'b1, 4'd5, 5'd9, 1'b1, 32'hFA5A_50F0});
         tick();
      end
      result_ready_i = 1'b1;
      chk("stall_first", {result_valid_o, result_id_o}, {1'b1, 4'd5});
      tick();
      chk("stall_second", {result_valid_o, result_id_o, result_data_o}, {1'b1, 4'd6, 32'hFFFF_0000});
      tick();
      chk("stall_done", {result_valid_o, busy_o}, 0);
      exp_ret += 2;

      result_ready_i = 1'b0;
      drive_issue(4'd7, BITREV, 32'h1, 32'h0, 5'd1, 1'b1);
      drive_issue(4'd8, BITREV, 32'h2, 32'h0, 5'd2, 1'b0);
      drive_issue(4'd9, BITREV, 32'h3, 32'h0, 5'd3, 1'b0);
      drive_issue(4'd10, BITREV, 32'h4, 32'h0, 5'd4, 1'b0);
      chk("prerst", {result_valid_o, result_id_o, busy_o}, {1'b1, 4'd7, 1'b1});
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst", {result_valid_o, busy_o, issue_ready_o}, 3'b001);
      tick();
      rst_ni = 1'b1;
      result_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_stale", {result_valid_o, busy_o}, 0);
      end
      exp_ret = 0;
      exp_kil = 0;
      chk("rst_perf2", {perf_retired_o, perf_killed_o}, 0);

      mon_q.delete();
      next_id    = 4'd0;
      prev_stall = 1'b0;
      prev       = '0;
      for (int c = 0; c < 400; c++) begin
         if (prev_stall)
            chk("rand_hold", {result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o}, prev);
         issue_valid_i = ($urandom % 3) != 0;
         issue_id_i    = next_id;
         issue_op_i    = copro_op_e'($urandom % 4);
         issue_rs1_i   = $urandom;
         issue_rs2_i   = $urandom;
         issue_rd_i    = 5'($urandom);
         if (issue_valid_i && issue_ready_o) begin
            e = '{id: next_id, op: issue_op_i, a: issue_rs1_i, b: issue_rs2_i, rd: issue_rd_i, kill: 1'b0};
            ents.push_back(e);
            pend.push_back(ents.size() - 1);
            next_id++;
         end
         commit_valid_i = 1'b0;
         commit_kill_i  = 1'b0;
         if (pend.size() > 0 && ($urandom % 2) == 1) begin
            k = int'($urandom % pend.size());
            commit_valid_i = 1'b1;
            commit_id_i    = ents[pend[k]].id;
            commit_kill_i  = ($urandom % 4) == 0;
            ents[pend[k]].kill = commit_kill_i;
            pend.delete(k);
         end
         result_ready_i = ($urandom % 4) != 0;
         prev_stall = result_valid_o && !result_ready_i;
         prev = {result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o};
         step();
      end
      issue_valid_i  = 1'b0;
      result_ready_i = 1'b1;
      while (pend.size() > 0) begin
         drive_commit(ents[pend[0]].id, 1'b0);
         pend.delete(0);
      end
      for (int i = 0; i < 100 && busy_o; i++) step();
      chk("rand_drain", busy_o, 0);

      nexp = 0;
      foreach (ents[i]) begin
         if (ents[i].kill) exp_kil++;
         else begin
            chk("rand_result", nexp < mon_q.size() ? mon_q[nexp] : 42'h0, m_pack(ents[i]));
            nexp++;
         end
      end
      exp_ret += nexp;
      chk("rand_count", mon_q.size(), nexp);
      chk("rand_perf", {perf_retired_o, perf_killed_o}, PERF ? {32'(exp_ret), 32'(exp_kil)} : 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
